mmio_oam_dma: RTL and testbench

- OAM DMA engine. Owns the DMA register at 0xFF46 as a `mem_if` slave.
- When software writes that register, the engine becomes a `mem_if` master on its own bus port. It copies DMA_LEN bytes from {src_hi, 8'h00} to DST_BASE.
- It is the initiator counterpart of the MMIO register slaves. It drives their two-cycle write-enable commit rule and samples their combinational `read_out`.
- Sits between the CPU-side MMIO decode and the memory arbiter. `busy` lets the arbiter block CPU accesses outside HRAM.

---
 rtl/mmio_oam_dma_pkg.sv | 25 ++
 rtl/mmio_oam_dma_if.sv | 32 +++
 rtl/mmio_oam_dma_we_commit.sv | 37 +++
 rtl/mmio_oam_dma.sv | 141 ++++++++++++++
 tb/tb_mmio_oam_dma.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_oam_dma_pkg.sv
// gb_mmio_pkg: shared definitions for the MMIO register slaves and the OAM DMA.
//   - Address constants for the DMA register and the OAM window.
//   - OPEN_BUS: value returned by a register port when its address is not selected.
//   - dma_state_t: OAM DMA engine state encoding.
//   - echo_map(): folds the echo-RAM window (E0xx-FFxx) down onto C0xx-DFxx.
package gb_mmio_pkg;

  localparam logic [15:0] ADDR_DMA      = 16'hFF46;
  localparam logic [15:0] ADDR_OAM_BASE = 16'hFE00;
  localparam logic [7:0]  OPEN_BUS      = 8'haa;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_DELAY = 3'd1,
    DMA_RD    = 3'd2,
    DMA_WR0   = 3'd3,
    DMA_WR1   = 3'd4
  } dma_state_t;

  // Source pages at or above E0 mirror work RAM; clearing bit 5 folds them back.
  function automatic logic [7:0] echo_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
  endfunction

endpackage

// File: rtl/mmio_oam_dma_if.sv
// mem_if: byte-wide memory-mapped bus shared by the MMIO register slaves and
// their initiators.
//   addr_select[15:0] : address driven by the master
//   write_enable      : write strobe driven by the master
//   write_value[7:0]  : write data driven by the master
//   read_out[7:0]     : combinational read data returned by the slave
//
// Handshake: there is no valid/ready pair. A read is combinational: read_out
// reflects addr_select in the same cycle. A write commits in the slave when
// write_enable stays high with the same address for two consecutive cycles;
// holding it longer commits only once, and write_enable must drop for at
// least one cycle before the next write can commit.
interface mem_if;
  logic [15:0] addr_select;
  logic        write_enable;
  logic [7:0]  write_value;
  logic [7:0]  read_out;

  modport master (
    output addr_select,
    output write_enable,
    output write_value,
    input  read_out
  );

  modport slave (
    input  addr_select,
    input  write_enable,
    input  write_value,
    output read_out
  );
endinterface

// File: rtl/mmio_oam_dma_we_commit.sv
// mmio_we_commit: write-commit detector for one MMIO register.
//   clk, rst  : clock, synchronous active-high reset
//   i_addr    : bus address
//   i_we      : bus write enable
//   o_commit  : one-cycle pulse on the second consecutive cycle of a write
//               to ADDR; a longer hold does not pulse again.
module mmio_we_commit
  import gb_mmio_pkg::*;
#(
  parameter logic [15:0] ADDR = ADDR_DMA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  output logic        o_commit
);

  logic       w_hit;
  logic [2:0] r_cnt;

  assign w_hit = i_we && (i_addr == ADDR);

  // Saturates so an arbitrarily long hold never wraps back through 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_hit) begin
      r_cnt <= '0;
    end else if (r_cnt != 3'd7) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_commit = w_hit && (r_cnt == 3'd1);

endmodule

// File: rtl/mmio_oam_dma.sv
// mmio_oam_dma: OAM DMA engine.
//   clk, rst    : clock, synchronous active-high reset
//   req         : mem_if slave, CPU-facing DMA source register at REG_ADDR
//   bus         : mem_if master, copies DMA_LEN bytes from {src,00} to DST_BASE
//   busy        : high while a transfer is pending (DELAY) or active
//   o_dbg_state : current engine state
// Each byte takes three cycles: RD (address the source, capture read_out),
// then WR0/WR1 holding the destination write for two cycles so the target
// slave commits it. The RD cycle keeps write_enable low between writes.
module mmio_oam_dma
  import gb_mmio_pkg::*;
#(
  parameter logic [15:0] REG_ADDR    = ADDR_DMA,
  parameter logic [15:0] DST_BASE    = ADDR_OAM_BASE,
  parameter int          DMA_LEN     = 160,
  parameter int          START_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_if.slave       req,
  mem_if.master      bus,
  output logic       busy,
  output dma_state_t o_dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  logic       w_commit;
  logic [7:0] w_eff_hi;
  logic [7:0] r_src_hi;
  dma_state_t r_state, w_state_nxt;
  logic [7:0] r_idx, w_idx_nxt;
  logic [7:0] r_dly;
  logic [7:0] r_data_q, w_data_nxt;
  logic [15:0] r_addr;
  logic        r_we;
  logic [7:0]  r_wv;
  logic        r_busy;

  mmio_we_commit #(.ADDR(REG_ADDR)) u_commit (
    .clk      (clk),
    .rst      (rst),
    .i_addr   (req.addr_select),
    .i_we     (req.write_enable),
    .o_commit (w_commit)
  );

  assign req.read_out = (req.addr_select == REG_ADDR) ? r_src_hi : OPEN_BUS;
  assign w_eff_hi     = echo_map(r_src_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_hi <= '0;
    end else if (w_commit) begin
      r_src_hi <= req.write_value;
    end
  end

  // Next state; a commit from any state restarts the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DMA_IDLE:  w_state_nxt = DMA_IDLE;
      DMA_DELAY: if (r_dly == DLY_LAST) w_state_nxt = DMA_RD;
      DMA_RD:    w_state_nxt = DMA_WR0;
      DMA_WR0:   w_state_nxt = DMA_WR1;
      DMA_WR1:   w_state_nxt = (r_idx < LAST_IDX) ? DMA_RD : DMA_IDLE;
      default:   w_state_nxt = DMA_IDLE;
    endcase
    if (w_commit) begin
      w_state_nxt = DMA_DELAY;
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_commit) begin
      w_idx_nxt = '0;
    end else if ((r_state == DMA_WR1) && (w_state_nxt == DMA_RD)) begin
      w_idx_nxt = r_idx + 8'd1;
    end
  end

  // The source byte is captured at the end of RD; WR0 needs it immediately.
  always_comb begin
    w_data_nxt = r_data_q;
    if (r_state == DMA_RD) begin
      w_data_nxt = bus.read_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DMA_IDLE;
      r_idx    <= '0;
      r_dly    <= '0;
      r_data_q <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_data_q <= w_data_nxt;
      r_busy   <= (w_state_nxt != DMA_IDLE);
      if (w_commit) begin
        r_dly <= '0;
      end else if (r_state == DMA_DELAY) begin
        r_dly <= r_dly + 8'd1;
      end
    end
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_wv   <= '0;
    end else begin
      case (w_state_nxt)
        DMA_RD: begin
          r_addr <= {w_eff_hi, w_idx_nxt};
          r_we   <= 1'b0;
        end
        DMA_WR0, DMA_WR1: begin
          r_addr <= DST_BASE + {8'h00, w_idx_nxt};
          r_wv   <= w_data_nxt;
          r_we   <= 1'b1;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign bus.addr_select  = r_addr;
  assign bus.write_enable = r_we;
  assign bus.write_value  = r_wv;
  assign busy             = r_busy;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mmio_oam_dma.sv
module tb_mmio_oam_dma;
  import gb_mmio_pkg::*;

  localparam int LEN = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  dma_state_t dbg_state;
  int         cyc = 0;

  mem_if req_if ();
  mem_if bus_if ();

  mmio_oam_dma dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req_if),
    .bus         (bus_if),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  assign bus_if.read_out = mem[bus_if.addr_select];

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic [15:0] rd_obs[$];
  int n_cmp = 0;
  int n_err = 0;
  int rise_cyc, fall_cyc, first_rd_cyc;
  int viol = 0;
  int run_len = 0;
  logic [15:0] run_addr, prev_addr = 16'h0000;
  logic [7:0]  run_val;
  logic        prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Bus monitor: emulates a target slave (2-cycle write commit), logs source
  // reads (WE low with a new address while busy) and busy edges, and counts
  // write-protocol violations.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (bus_if.write_enable) begin
      if (run_len == 0) begin
        run_addr = bus_if.addr_select;
        run_val  = bus_if.write_value;
      end else if (bus_if.addr_select != run_addr || bus_if.write_value != run_val) begin
        viol++;
      end
      run_len++;
      if (run_len == 2) mem[bus_if.addr_select] = bus_if.write_value;
    end else begin
      if (run_len != 0 && run_len != 2) viol++;
      run_len = 0;
      if (busy && bus_if.addr_select != prev_addr) begin
        rd_obs.push_back(bus_if.addr_select);
        if (rd_obs.size() == 1) first_rd_cyc = cyc;
      end
    end
    if (busy && !prev_busy) rise_cyc = cyc;
    if (!busy && prev_busy) fall_cyc = cyc;
    prev_busy = busy;
    prev_addr = bus_if.addr_select;
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic [7:0] v, input int hold, output int commit_cyc);
    @(posedge clk); #1;
    req_if.addr_select  = ADDR_DMA;
    req_if.write_value  = v;
    req_if.write_enable = 1'b1;
    commit_cyc = cyc + 1;
    repeat (hold) @(posedge clk);
    #1 req_if.write_enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_obs();
    rd_obs.delete();
    rise_cyc = -1;
    fall_cyc = -1;
    first_rd_cyc = -1;
  endtask

  // Compare observed source reads and the OAM image against the expectations.
  task automatic verify(input string tag);
    chk({tag, "_rd_cnt"}, rd_obs.size(), exp_addr_q.size());
    for (int i = 0; exp_addr_q.size() > 0; i++) begin
      logic [15:0] e = exp_addr_q.pop_front();
      chk({tag, "_rd_addr"}, (i < rd_obs.size()) ? rd_obs[i] : 16'hxxxx, e);
    end
    for (int i = 0; i < LEN; i++) begin
      chk({tag, "_oam"}, mem[16'hFE00 + i], exp_q.pop_front());
    end
  endtask

  // Sets up expectations for a copy from page hi, poisons OAM, runs it.
  task automatic do_transfer(input string tag, input logic [7:0] hi, input int hold);
    logic [7:0] eff;
    int c;
    eff = (hi >= 8'hE0) ? hi - 8'h20 : hi;
    for (int i = 0; i < LEN; i++) begin
      mem[16'hFE00 + i] = ~mem[{eff, 8'(i)}];
      exp_q.push_back(mem[{eff, 8'(i)}]);
      exp_addr_q.push_back({eff, 8'(i)});
    end
    clear_obs();
    reg_write(hi, hold, c);
    req_if.addr_select = 16'(($urandom_range(0, 32'hFF45)));
    #1 chk({tag, "_open_bus"}, req_if.read_out, 8'haa);
    req_if.addr_select = ADDR_DMA;
    #1 chk({tag, "_reg_busy"}, req_if.read_out, hi);
    wait_idle(600);
    chk({tag, "_rise"}, rise_cyc, c + 1);
    chk({tag, "_first_rd"}, first_rd_cyc, c + 5);
    chk({tag, "_busy_len"}, fall_cyc - rise_cyc, 484);
    chk({tag, "_reg_after"}, req_if.read_out, hi);
    verify(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c1, c2;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
    req_if.addr_select  = ADDR_DMA;
    req_if.write_enable = 1'b0;
    req_if.write_value  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", bus_if.write_enable, 0);
    chk("rst_addr", bus_if.addr_select, 16'h0000);
    chk("rst_wv", bus_if.write_value, 8'h00);
    chk("rst_reg", req_if.read_out, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    do_transfer("basic", 8'hC0, 2);
    do_transfer("echo", 8'hE1, 2);
    do_transfer("long_we", 8'hC0, 5);

    // Retrigger with D0 while byte 50 of a C0 copy is being read.
    for (int i = 0; i < LEN; i++) begin
      mem[16'hFE00 + i] = ~mem[16'hD000 + i];
      exp_q.push_back(mem[16'hD000 + i]);
    end
    for (int i = 0; i <= 50; i++) exp_addr_q.push_back(16'hC000 + 16'(i));
    for (int i = 0; i < LEN; i++) exp_addr_q.push_back(16'hD000 + 16'(i));
    clear_obs();
    reg_write(8'hC0, 2, c1);
    while (cyc < c1 + 153) begin
      @(posedge clk); #1;
    end
    reg_write(8'hD0, 2, c2);
    wait_idle(700);
    chk("retrig_rise", rise_cyc, c1 + 1);
    chk("retrig_busy_len", fall_cyc - rise_cyc, (c2 - c1) + 484);
    chk("retrig_reg", req_if.read_out, 8'hD0);
    verify("retrig");

    // Randomized source pages (echo included) and write-enable hold lengths.
    for (int k = 0; k < 3; k++) begin
      do_transfer("rand", 8'($urandom_range(1, 8'hFD)), $urandom_range(2, 9));
    end

    // Reset in the middle of a transfer.
    reg_write(8'h40, 2, c1);
    repeat ($urandom_range(60, 200)) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", bus_if.write_enable, 0);
    chk("mid_rst_addr", bus_if.addr_select, 16'h0000);
    chk("mid_rst_reg", req_if.read_out, 8'h00);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    do_transfer("post_rst", 8'h81, 2);

    chk("proto_viol", viol, 0);
    chk("proto_open_run", run_len, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
